// File: rtl/dram_arbiter_4_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dram_arbiter_4_pkg
// Brief    : Shared FSM encoding, requester IDs and default widths for the
//            4-core data-memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package dram_arbiter_4_pkg;

    localparam int DEF_ADDR_W = 9;
    localparam int DEF_DATA_W = 16;
    localparam int CNT_W      = 16;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_WAIT   = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    // IDs 0..3 are cores, 4 is the external load/readback port
    typedef logic [2:0] req_id_t;
    localparam req_id_t ID_EXT = 3'd4;

    function automatic logic is_core(input req_id_t id);
        return !id[2];
    endfunction

endpackage
`default_nettype wire

// File: rtl/dram_arbiter_4_if.sv
`default_nettype none
// ============================================================================
// Module   : dram_arbiter_4_if
// Brief    : Requester and data-memory bus bundle seen by the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface dram_arbiter_4_if
    import dram_arbiter_4_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic [3:0]          core_req;
    logic [3:0]          core_we;
    logic [4*ADDR_W-1:0] core_addr;
    logic [4*DATA_W-1:0] core_wdata;
    logic [3:0]          core_ack;
    logic [DATA_W-1:0]   core_rdata;
    logic                ext_req;
    logic                ext_we;
    logic [ADDR_W-1:0]   ext_addr;
    logic [DATA_W-1:0]   ext_wdata;
    logic                ext_ack;
    logic [ADDR_W-1:0]   dram_addr;
    logic [DATA_W-1:0]   dram_wdata;
    logic                dram_we;
    logic                dram_re;
    logic [DATA_W-1:0]   dram_rdata;
    logic                busy;

    modport slave (
        input  core_req, core_we, core_addr, core_wdata,
        input  ext_req, ext_we, ext_addr, ext_wdata,
        input  dram_rdata,
        output core_ack, core_rdata, ext_ack,
        output dram_addr, dram_wdata, dram_we, dram_re, busy
    );

    modport master (
        output core_req, core_we, core_addr, core_wdata,
        output ext_req, ext_we, ext_addr, ext_wdata,
        output dram_rdata,
        input  core_ack, core_rdata, ext_ack,
        input  dram_addr, dram_wdata, dram_we, dram_re, busy
    );
endinterface
`default_nettype wire

// File: rtl/dram_arbiter_4_rr_pick_4.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick_4
// Brief    : Combinational 4-way round-robin picker; first set req bit
//            searching upward from ptr modulo 4.
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick_4 (
    input  wire logic [3:0] req,
    input  wire logic [1:0] ptr,
    output logic            valid,
    output logic [1:0]      idx
);
    // Walk offsets high-to-low so the smallest offset from ptr wins
    always_comb begin
        valid = 1'b0;
        idx   = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (req[ptr + 2'(k)]) begin
                valid = 1'b1;
                idx   = ptr + 2'(k);
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/dram_arbiter_4.sv
`default_nettype none
// ============================================================================
// Module   : dram_arbiter_4
// Brief    : Single-port data memory arbiter; external port has absolute
//            priority, four cores served round-robin, one access in flight.
//            Optional macro DRAM_ARB_STATS_EN adds per-core grant counters.
// Revision : 1.0 - initial release
// ============================================================================
module dram_arbiter_4
    import dram_arbiter_4_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int RD_LAT = 1
) (
    input  wire logic            clock,
    input  wire logic            reset,
`ifdef DRAM_ARB_STATS_EN
    input  wire logic            stats_clr,
    output logic [4*CNT_W-1:0]   grant_count,
`endif
    dram_arbiter_4_if.slave      bus
);
    localparam logic [1:0] c_rd_lat_m1 = 2'(RD_LAT - 1);

    logic [1:0]        state_q,  state_d;
    logic [1:0]        rr_ptr_q, rr_ptr_d;
    req_id_t           owner_q,  owner_d;
    logic              we_q,     we_d;
    logic [ADDR_W-1:0] addr_q,   addr_d;
    logic [DATA_W-1:0] wdata_q,  wdata_d;
    logic [DATA_W-1:0] rdata_q,  rdata_d;
    logic [1:0]        cnt_q,    cnt_d;

    logic              w_pick_valid;
    logic [1:0]        w_pick_idx;
    logic              w_resp;

    rr_pick_4 u_pick (
        .req   (bus.core_req),
        .ptr   (rr_ptr_q),
        .valid (w_pick_valid),
        .idx   (w_pick_idx)
    );

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        cnt_d    = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.ext_req) begin
                    owner_d = ID_EXT;
                    we_d    = bus.ext_we;
                    addr_d  = bus.ext_addr;
                    wdata_d = bus.ext_wdata;
                    state_d = ST_ACCESS;
                end else if (w_pick_valid) begin
                    owner_d = {1'b0, w_pick_idx};
                    we_d    = bus.core_we[w_pick_idx];
                    addr_d  = bus.core_addr[w_pick_idx*ADDR_W +: ADDR_W];
                    wdata_d = bus.core_wdata[w_pick_idx*DATA_W +: DATA_W];
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (we_q) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d   = c_rd_lat_m1;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 2'd0) begin
                    rdata_d = bus.dram_rdata;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            ST_RESP: begin
                // External grants leave the core rotation untouched
                if (is_core(owner_q)) begin
                    rr_ptr_d = owner_q[1:0] + 2'd1;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            cnt_q    <= cnt_d;
        end
    end

    assign w_resp         = (state_q == ST_RESP);
    assign bus.dram_addr  = addr_q;
    assign bus.dram_wdata = wdata_q;
    assign bus.dram_we    = (state_q == ST_ACCESS) &&  we_q;
    assign bus.dram_re    = (state_q == ST_ACCESS) && !we_q;
    assign bus.core_ack   = (w_resp && is_core(owner_q)) ? (4'b0001 << owner_q[1:0]) : 4'b0000;
    assign bus.ext_ack    = w_resp && (owner_q == ID_EXT);
    assign bus.core_rdata = rdata_q;
    assign bus.busy       = (state_q != ST_IDLE);

`ifdef DRAM_ARB_STATS_EN
    logic [CNT_W-1:0] grant_cnt_q [4];
    logic [CNT_W-1:0] grant_cnt_d [4];

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            grant_cnt_d[i] = grant_cnt_q[i];
            if (stats_clr) begin
                grant_cnt_d[i] = '0;
            end else if (w_resp && is_core(owner_q) && (owner_q[1:0] == 2'(i))
                         && (grant_cnt_q[i] != {CNT_W{1'b1}})) begin
                grant_cnt_d[i] = grant_cnt_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        for (int i = 0; i < 4; i++) begin
            if (reset) grant_cnt_q[i] <= '0;
            else       grant_cnt_q[i] <= grant_cnt_d[i];
        end
    end

    generate
        for (genvar g = 0; g < 4; g++) begin : g_stats_out
            assign grant_count[g*CNT_W +: CNT_W] = grant_cnt_q[g];
        end
    endgenerate
`endif

endmodule
`default_nettype wire

// File: tb/tb_dram_arbiter_4.sv
`default_nettype none
// ============================================================================
// Module   : tb_dram_arbiter_4
// Brief    : Directed self-checking bench for dram_arbiter_4 with RD_LAT=2.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_dram_arbiter_4;
    localparam int ADDR_W = 9;
    localparam int DATA_W = 16;
    localparam int RD_LAT = 2;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clock = ~clock;

    dram_arbiter_4_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

`ifdef DRAM_ARB_STATS_EN
    logic        stats_clr = 1'b0;
    logic [63:0] grant_count;
`endif

    dram_arbiter_4 #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
        .clock       (clock),
        .reset       (reset),
`ifdef DRAM_ARB_STATS_EN
        .stats_clr   (stats_clr),
        .grant_count (grant_count),
`endif
        .bus         (bus)
    );

    // Two-stage read pipeline: data sampled by the arbiter two edges after dram_re
    logic [DATA_W-1:0] mem [0:511];
    logic [DATA_W-1:0] rd_stage = '0;
    always @(posedge clock) begin
        if (bus.dram_we) mem[bus.dram_addr] <= bus.dram_wdata;
        if (bus.dram_re) rd_stage <= mem[bus.dram_addr];
        bus.dram_rdata <= rd_stage;
    end

    task automatic set_core(input int i, input logic we, input logic [ADDR_W-1:0] a,
                            input logic [DATA_W-1:0] d);
        bus.core_we[i]                     = we;
        bus.core_addr[i*ADDR_W +: ADDR_W]  = a;
        bus.core_wdata[i*DATA_W +: DATA_W] = d;
        bus.core_req[i]                    = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clock);
        checks++; if (bus.core_ack !== 4'b0 || bus.ext_ack !== 1'b0)
            begin errors++; $display("FAIL reset_acks: core_ack=%b ext_ack=%b, want 0", bus.core_ack, bus.ext_ack); end
        checks++; if ({bus.dram_we, bus.dram_re, bus.busy} !== 3'b000)
            begin errors++; $display("FAIL reset_strobes: we/re/busy=%b, want 000", {bus.dram_we, bus.dram_re, bus.busy}); end
        checks++; if (bus.core_rdata !== '0 || bus.dram_addr !== '0 || bus.dram_wdata !== '0)
            begin errors++; $display("FAIL reset_data: rdata=%h addr=%h wdata=%h, want 0", bus.core_rdata, bus.dram_addr, bus.dram_wdata); end
        reset = 1'b0;
    endtask

    task automatic test_single_write();
        set_core(1, 1'b1, 9'd5, 16'h1234);
        @(negedge clock);
        checks++; if ({bus.dram_we, bus.dram_re} !== 2'b10 || bus.dram_addr !== 9'd5 || bus.dram_wdata !== 16'h1234)
            begin errors++; $display("FAIL wr_access: we/re=%b addr=%0d data=%h, want 10/5/1234", {bus.dram_we, bus.dram_re}, bus.dram_addr, bus.dram_wdata); end
        checks++; if (bus.core_ack !== 4'b0)
            begin errors++; $display("FAIL wr_early_ack: core_ack=%b, want 0000", bus.core_ack); end
        @(negedge clock);
        checks++; if (bus.core_ack !== 4'b0010 || bus.ext_ack !== 1'b0 || bus.dram_we !== 1'b0)
            begin errors++; $display("FAIL wr_ack: core_ack=%b ext=%b we=%b, want 0010/0/0", bus.core_ack, bus.ext_ack, bus.dram_we); end
        bus.core_req[1] = 1'b0;
        @(negedge clock);
        checks++; if (bus.core_ack !== 4'b0 || bus.busy !== 1'b0)
            begin errors++; $display("FAIL wr_done: core_ack=%b busy=%b, want 0000/0", bus.core_ack, bus.busy); end
        checks++; if (mem[5] !== 16'h1234 || bus.core_rdata !== 16'h0)
            begin errors++; $display("FAIL wr_mem: mem5=%h rdata=%h, want 1234/0000", mem[5], bus.core_rdata); end
    endtask

    task automatic test_read_back();
        set_core(1, 1'b0, 9'd5, 16'h0);
        @(negedge clock);
        checks++; if ({bus.dram_we, bus.dram_re} !== 2'b01 || bus.dram_addr !== 9'd5)
            begin errors++; $display("FAIL rd_access: we/re=%b addr=%0d, want 01/5", {bus.dram_we, bus.dram_re}, bus.dram_addr); end
        @(negedge clock);
        @(negedge clock);
        checks++; if (bus.core_ack !== 4'b0 || bus.dram_re !== 1'b0)
            begin errors++; $display("FAIL rd_wait: core_ack=%b re=%b, want 0000/0", bus.core_ack, bus.dram_re); end
        @(negedge clock);
        checks++; if (bus.core_ack !== 4'b0010 || bus.core_rdata !== 16'h1234)
            begin errors++; $display("FAIL rd_ack: core_ack=%b rdata=%h, want 0010/1234", bus.core_ack, bus.core_rdata); end
        bus.core_req[1] = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_rdata_hold();
        set_core(0, 1'b1, 9'd7, 16'hBEEF);
        @(negedge clock);
        @(negedge clock);
        checks++; if (bus.core_ack !== 4'b0001 || bus.core_rdata !== 16'h1234)
            begin errors++; $display("FAIL rdata_hold: core_ack=%b rdata=%h, want 0001/1234", bus.core_ack, bus.core_rdata); end
        bus.core_req[0] = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_contention();
        int n   = 0;
        int bad = 0;
        logic [3:0] exp;
        reset = 1'b1;
        for (int i = 0; i < 4; i++) set_core(i, 1'b1, 9'(10 + i), 16'(16'hA000 + i));
        repeat (2) @(negedge clock);
        reset = 1'b0;
        for (int cyc = 0; cyc < 40 && n < 8; cyc++) begin
            @(negedge clock);
            if ($countones({bus.core_ack, bus.ext_ack}) > 1) bad++;
            if (bus.core_ack !== 4'b0) begin
                exp = 4'b0001 << (n % 4);
                checks++; if (bus.core_ack !== exp)
                    begin errors++; $display("FAIL rr_order[%0d]: core_ack=%b, want %b", n, bus.core_ack, exp); end
                n++;
            end
        end
        bus.core_req = 4'b0;
        checks++; if (n !== 8)
            begin errors++; $display("FAIL rr_timeout: acks=%0d, want 8", n); end
        checks++; if (bad !== 0 || mem[13] !== 16'hA003)
            begin errors++; $display("FAIL rr_onehot: multi-ack cycles=%0d mem13=%h, want 0/a003", bad, mem[13]); end
        repeat (2) @(negedge clock);
    endtask

    task automatic test_ext_priority();
        int exp_id [3]  = '{4, 0, 1};
        int exp_cyc [3] = '{2, 5, 8};
        int n = 0;
        int id;
        bus.ext_we = 1'b1; bus.ext_addr = 9'd20; bus.ext_wdata = 16'h5555; bus.ext_req = 1'b1;
        set_core(0, 1'b1, 9'd21, 16'h6666);
        set_core(1, 1'b1, 9'd22, 16'h7777);
        for (int cyc = 1; cyc <= 30 && n < 3; cyc++) begin
            @(negedge clock);
            if (bus.ext_ack === 1'b1 || bus.core_ack !== 4'b0) begin
                id = bus.ext_ack ? 4 : (bus.core_ack == 4'b0001 ? 0 : bus.core_ack == 4'b0010 ? 1 :
                                        bus.core_ack == 4'b0100 ? 2 : 3);
                checks++; if (id !== exp_id[n] || cyc !== exp_cyc[n])
                    begin errors++; $display("FAIL ext_order[%0d]: id=%0d cycle=%0d, want %0d/%0d", n, id, cyc, exp_id[n], exp_cyc[n]); end
                if (id == 4) bus.ext_req = 1'b0;
                else         bus.core_req[id] = 1'b0;
                n++;
            end
        end
        bus.ext_req = 1'b0; bus.core_req = 4'b0;
        checks++; if (n !== 3)
            begin errors++; $display("FAIL ext_timeout: acks=%0d, want 3", n); end
        checks++; if (mem[20] !== 16'h5555 || mem[22] !== 16'h7777)
            begin errors++; $display("FAIL ext_mem: mem20=%h mem22=%h, want 5555/7777", mem[20], mem[22]); end
        @(negedge clock);
    endtask

    task automatic test_reset_mid_read();
        int spurious = 0;
        set_core(2, 1'b0, 9'd5, 16'h0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        checks++; if ({bus.dram_we, bus.dram_re, bus.busy} !== 3'b000 || bus.core_ack !== 4'b0 || bus.core_rdata !== '0)
            begin errors++; $display("FAIL midrst_abort: we/re/busy=%b ack=%b rdata=%h, want 000/0000/0", {bus.dram_we, bus.dram_re, bus.busy}, bus.core_ack, bus.core_rdata); end
        bus.core_req[2] = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        set_core(3, 1'b0, 9'd5, 16'h0);
        repeat (3) begin
            @(negedge clock);
            if (bus.core_ack !== 4'b0) spurious++;
        end
        @(negedge clock);
        checks++; if (spurious !== 0 || bus.core_ack !== 4'b1000 || bus.core_rdata !== 16'h1234)
            begin errors++; $display("FAIL midrst_regrant: spurious=%0d ack=%b rdata=%h, want 0/1000/1234", spurious, bus.core_ack, bus.core_rdata); end
        bus.core_req[3] = 1'b0;
        @(negedge clock);
    endtask

`ifdef DRAM_ARB_STATS_EN
    task automatic test_stats();
        for (int k = 0; k < 3; k++) begin
            set_core(2, 1'b1, 9'(30 + k), 16'(k));
            repeat (2) @(negedge clock);
            bus.core_req[2] = 1'b0;
            @(negedge clock);
        end
        checks++; if (grant_count[47:32] !== 16'd3 || grant_count[63:48] !== 16'd1)
            begin errors++; $display("FAIL stats_count: core3=%0d core4=%0d, want 3/1", grant_count[47:32], grant_count[63:48]); end
        stats_clr = 1'b1;
        @(negedge clock);
        stats_clr = 1'b0;
        checks++; if (grant_count !== 64'h0)
            begin errors++; $display("FAIL stats_clr: grant_count=%h, want 0", grant_count); end
    endtask
`endif

    initial begin
        bus.core_req = '0; bus.core_we = '0; bus.core_addr = '0; bus.core_wdata = '0;
        bus.ext_req = 1'b0; bus.ext_we = 1'b0; bus.ext_addr = '0; bus.ext_wdata = '0;
        for (int a = 0; a < 512; a++) mem[a] = '0;
        test_reset();
        test_single_write();
        test_read_back();
        test_rdata_hold();
        test_contention();
        test_ext_priority();
        test_reset_mid_read();
`ifdef DRAM_ARB_STATS_EN
        test_stats();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dram_arbiter_4.md
Name: dram_arbiter_4

Overview:
- Shares the single-port data memory between the four processor cores and the external load/readback port.
- Sits between the core memory interfaces and the data memory inside the 4-core top level.
- External port has absolute priority; the four cores are served round-robin.
- One access is in flight at a time: a registered request/acknowledge handshake per requester, with fixed-latency reads.

Parameters:
- ADDR_W, 9, data memory address width.
- DATA_W, 16, data word width.
- RD_LAT, 1, data memory read latency in cycles (legal range 1..4).

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- core_req  in  4  per-core access request; bit i = core i+1.
- core_we  in  4  per-core write (1) / read (0) select.
- core_addr  in  4*ADDR_W  per-core address, packed; core i at [i*ADDR_W +: ADDR_W].
- core_wdata  in  4*DATA_W  per-core write data, packed.
- core_ack  out  4  one-cycle completion pulse per core.
- core_rdata  out  DATA_W  read data; valid only while the relevant core_ack bit is high.
- ext_req  in  1  external port request.
- ext_we  in  1  external write/read select.
- ext_addr  in  ADDR_W  external address.
- ext_wdata  in  DATA_W  external write data.
- ext_ack  out  1  one-cycle external completion pulse.
- dram_addr  out  ADDR_W  memory address.
- dram_wdata  out  DATA_W  memory write data.
- dram_we  out  1  memory write strobe.
- dram_re  out  1  memory read strobe.
- dram_rdata  in  DATA_W  memory read data.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (synchronous, sampled on the rising edge):
  - All outputs go to 0; FSM goes to IDLE; round-robin pointer rr_ptr goes to 0 (core 1 has highest priority).
  - Reset mid-access aborts the access with no ack. dram_we and dram_re are low from the edge on which reset is sampled.
- Request rules:
  - A requester holds req, we, addr and wdata stable from req assertion until it sees its ack.
  - Req may drop in the cycle after ack. Ack is never issued to a requester whose req was low when it was granted.
- FSM states: IDLE, ACCESS, WAIT, RESP.
- IDLE:
  - If ext_req is high, grant the external port.
  - Otherwise grant the first set core_req bit, searching from rr_ptr upward modulo 4.
  - On a grant: latch the winner's addr/wdata/we and go to ACCESS.
  - With no request, stay in IDLE.
- ACCESS (exactly 1 cycle):
  - Drive dram_addr and dram_wdata.
  - Drive dram_we = we, dram_re = !we.
  - Writes go to RESP. Reads go to WAIT with the counter loaded to RD_LAT-1.
  - If RD_LAT=1, the WAIT stay is a single cycle.
- WAIT:
  - Strobes are low; decrement the counter.
  - At count 0, capture dram_rdata into core_rdata and go to RESP.
- RESP (1 cycle):
  - Pulse the winner's ack.
  - If the winner is a core, set rr_ptr = winner+1 mod 4. External grants do not move rr_ptr.
  - Return to IDLE.
- Latency from req seen in IDLE to ack:
  - Write: 2 cycles.
  - Read: 2+RD_LAT cycles.
- Minimum inter-grant gap is one IDLE cycle.
- Simultaneous events:
  - ext_req together with any core_req: ext wins.
  - All four cores requesting: granted in order rr_ptr, rr_ptr+1, … with no starvation. Each core waits at most 3 core accesses, plus any ext accesses.
- core_rdata holds its last captured value between reads. Write acks do not alter it.
- At most one bit of {core_ack, ext_ack} is high in any cycle.

Optional Feature:
- Macro: DRAM_ARB_STATS_EN.
- When defined:
  - Adds four 16-bit saturating grant counters, one per core, incremented in RESP.
  - Adds output port grant_count (4*16, packed) and input stats_clr, which synchronously zeros the counters.
  - reset also clears the counters.
- When undefined: no counters and no extra ports; behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - FSM state encoding (ST_IDLE, ST_ACCESS, ST_WAIT, ST_RESP; 2 bits).
  - Requester ID encoding: 0–3 = cores, 4 = ext; 3 bits.
  - Default widths ADDR_W and DATA_W.
- One sub-module, rr_pick_4: combinational 4-way round-robin picker.
  - Inputs: req[3:0], ptr[1:0].
  - Outputs: valid, idx[1:0].
- The arbiter FSM, latches and counters stay in the top module.

Test Plan:
- Single write: core 2 writes 0x1234 to addr 5 → dram_we high for 1 cycle with addr 5 / data 0x1234; core_ack = 4'b0010 exactly 2 cycles after req.
- Read-back with RD_LAT=2: core 2 reads addr 5 → core_ack[1] at cycle 4; core_rdata = 0x1234.
- All-core contention: core_req = 4'b1111 held from reset → grant order cores 1,2,3,4,1, …; no core acked twice before all others have been acked once.
- External priority: ext_req with core_req = 4'b0001 simultaneously → ext_ack first, core 1 next; rr_ptr unchanged by the ext grant.
- Reset mid-read: assert reset during WAIT → no ack, strobes low; after reset, core_req = 4'b1000 is granted normally.
- Stats (DRAM_ARB_STATS_EN): 3 accesses by core 3 → grant_count[47:32] = 3; pulse stats_clr → 0.
